// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detection, oversampling edge counter, sampler
// enable, LSB-first deserialization, optional parity check and stop-bit check.
// The voted bit from the external sampler is consumed on the last edge of each bit.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  data_samp_en,
  output logic [4:0]            edge_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e state_q, state_d;

  logic [4:0]            edge_cnt_q, edge_cnt_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_bad_q, par_bad_d;

  logic       prescale_ok;
  logic [4:0] last_edge;
  logic       bit_end;
  logic       last_bit;
  logic       start_det;

  // Only power-of-two ratios 4..32 are supported; anything else parks the block in idle.
  assign prescale_ok = (Prescale == 6'd4) || (Prescale == 6'd8) ||
                       (Prescale == 6'd16) || (Prescale == 6'd32);
  assign last_edge   = 5'(Prescale - 6'd1);
  assign bit_end     = (edge_cnt_q == last_edge);
  assign last_bit    = (bit_cnt_q == BitCntW'(DATA_WIDTH - 1));
  assign start_det   = (state_q == StIdle) && prescale_ok && !RX_IN;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: transitions happen only on bit-end cycles, except start detection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_det) state_d = StStart;
      end
      StStart: begin
        if (bit_end) state_d = sampled_bit ? StIdle : StData;
      end
      StData: begin
        if (bit_end && last_bit) state_d = par_en_q ? StParity : StStop;
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: the sampler runs during a frame and on the start-detect cycle.
  always_comb begin
    data_samp_en = (state_q != StIdle) || start_det;
  end

  // Datapath next-state: edge counter, shifter, parity tracking and result strobes.
  always_comb begin
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_bad_d    = par_bad_q;

    if (state_q == StIdle) begin
      // The detect cycle itself is edge 0 of the start bit.
      edge_cnt_d = start_det ? 5'd1 : 5'd0;
      if (start_det) begin
        bit_cnt_d = '0;
        par_en_d  = PAR_EN;
        par_typ_d = PAR_TYP;
        par_bad_d = 1'b0;
      end
    end else begin
      edge_cnt_d = bit_end ? 5'd0 : edge_cnt_q + 5'd1;
    end

    if (bit_end) begin
      unique case (state_q)
        StStart: begin
          bit_cnt_d = '0;
        end
        StData: begin
          shreg_d   = {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        StParity: begin
          par_bad_d = ((^shreg_q) ^ par_typ_q) != sampled_bit;
        end
        StStop: begin
          stp_err_d = !sampled_bit;
          par_err_d = par_bad_q;
          if (sampled_bit && !par_bad_q) begin
            data_valid_d = 1'b1;
            p_data_d     = shreg_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad_q    <= 1'b0;
    end else begin
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_bad_q    <= par_bad_d;
    end
  end

  assign edge_cnt   = edge_cnt_q;
  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed table, hand-written corner
// sequences and randomized frames checked against a frame-level reference model.
module tb_uart_rx_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          RX_IN;
  logic [5:0]    Prescale;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          sampled_bit;
  logic          data_samp_en;
  logic [4:0]    edge_cnt;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .sampled_bit  (sampled_bit),
    .data_samp_en (data_samp_en),
    .edge_cnt     (edge_cnt),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .par_err      (par_err),
    .stp_err      (stp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [2:0]    flags;  // {data_valid, par_err, stp_err}
    logic [DW-1:0] pdata;
  } ev_t;

  ev_t act_q[$];
  ev_t exp_q[$];
  ev_t mon_e;

  // Record every strobe cycle seen on the outputs.
  always @(negedge clk) begin
    if (rst === 1'b1 && (data_valid || par_err || stp_err)) begin
      mon_e.cyc   = cyc;
      mon_e.flags = {data_valid, par_err, stp_err};
      mon_e.pdata = P_DATA;
      act_q.push_back(mon_e);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] last_good = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input bit rx, input bit sb);
    @(negedge clk);
    RX_IN       = rx;
    sampled_bit = sb;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b1);
  endtask

  // Drive a full frame; each bit is held for p cycles and the sampler votes the bit value.
  task automatic send_frame(input int p, input logic [DW-1:0] d, input bit pe, input bit pt,
                            input bit flip, input bit stop, output int c0);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ pt ^ flip);
    bits.push_back(stop);
    c0 = 0;
    for (int i = 0; i < bits.size(); i++) begin
      for (int j = 0; j < p; j++) begin
        @(negedge clk);
        if (i == 0 && j == 0) begin
          Prescale = 6'(p);
          PAR_EN   = pe;
          PAR_TYP  = pt;
          c0       = cyc;
        end
        RX_IN       = bits[i];
        sampled_bit = bits[i];
      end
    end
  endtask

  // Reference model: one result per frame, N bit periods after the start-detect cycle.
  task automatic expect_frame(input int p, input logic [DW-1:0] d, input bit pe, input bit flip,
                              input bit stop, input int c0);
    ev_t e;
    bit  bad_par;
    bit  good;
    bad_par = pe && flip;
    good    = stop && !bad_par;
    if (good) last_good = d;
    e.cyc   = c0 + (DW + 2 + (pe ? 1 : 0)) * p;
    e.flags = {good, bad_par, !stop};
    e.pdata = last_good;
    exp_q.push_back(e);
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, " event count"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " event cycle"}, act_q[i].cyc, exp_q[i].cyc);
      check({tag, " strobes"}, 32'(act_q[i].flags), 32'(exp_q[i].flags));
      check({tag, " P_DATA"}, 32'(act_q[i].pdata), 32'(exp_q[i].pdata));
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    check({tag, " edge_cnt"}, 32'(edge_cnt), 0);
    check({tag, " data_samp_en"}, 32'(data_samp_en), 0);
    check({tag, " P_DATA"}, 32'(P_DATA), 0);
    check({tag, " strobes"}, {29'd0, data_valid, par_err, stp_err}, 0);
  endtask

  typedef struct {
    int            p;
    logic [DW-1:0] d;
    bit            pe, pt, flip, stop;
    bit            x_dv, x_pe, x_se;
    logic [DW-1:0] x_pd;
    int            x_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int c0;
    int c1;
    int plist[4];

    vecs[0] = '{8,  8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 80};
    vecs[1] = '{16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 176};
    vecs[2] = '{16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 176};
    vecs[3] = '{32, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 320};
    vecs[4] = '{8,  8'h96, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h96, 88};
    vecs[5] = '{4,  8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h96, 44};
    plist = '{4, 8, 16, 32};

    rst         = 1'b0;
    RX_IN       = 1'b1;
    sampled_bit = 1'b1;
    Prescale    = 6'd8;
    PAR_EN      = 1'b0;
    PAR_TYP     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    idle(3);

    // Directed table.
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].p, vecs[v].d, vecs[v].pe, vecs[v].pt, vecs[v].flip, vecs[v].stop, c0);
      idle(3);
      check($sformatf("vec%0d event count", v), act_q.size(), 1);
      if (act_q.size() == 1) begin
        check($sformatf("vec%0d latency", v), act_q[0].cyc - c0, vecs[v].x_lat);
        check($sformatf("vec%0d strobes", v), 32'(act_q[0].flags),
              {29'd0, vecs[v].x_dv, vecs[v].x_pe, vecs[v].x_se});
        check($sformatf("vec%0d P_DATA", v), 32'(act_q[0].pdata), 32'(vecs[v].x_pd));
      end
      act_q.delete();
      last_good = vecs[v].x_pd;
    end

    // Back-to-back frames with no idle gap.
    send_frame(8, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, c0);
    expect_frame(8, 8'h12, 1'b0, 1'b0, 1'b1, c0);
    send_frame(8, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, c1);
    expect_frame(8, 8'h34, 1'b0, 1'b0, 1'b1, c1);
    idle(3);
    check("b2b second start", c1 - c0, 80);
    compare_events("b2b");

    // Start glitch at Prescale=4: false start, back in idle at cycle 4.
    Prescale = 6'd4;
    idle(2);
    drive(1'b0, 1'b1);
    c0 = cyc;
    #1 check("glitch samp_en at detect", 32'(data_samp_en), 1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    #1 check("glitch edge_cnt at cycle 3", 32'(edge_cnt), 3);
    drive(1'b1, 1'b1);
    #1;
    check("glitch cycle", cyc - c0, 4);
    check("glitch edge_cnt at cycle 4", 32'(edge_cnt), 0);
    check("glitch samp_en at cycle 4", 32'(data_samp_en), 0);
    idle(3);
    compare_events("glitch");

    // Break: line held low through the stop bit, then immediate re-detect.
    send_frame(8, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, c0);
    expect_frame(8, 8'h00, 1'b0, 1'b0, 1'b0, c0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    #1;
    check("break re-detect edge_cnt", 32'(edge_cnt), 1);
    check("break re-detect samp_en", 32'(data_samp_en), 1);
    repeat (6) drive(1'b1, 1'b1);
    idle(3);
    #1 check("break back to idle", 32'(edge_cnt), 0);
    compare_events("break");

    // Reset mid-frame, then a clean frame.
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bit b;
      b = (i < 8) ? 1'b0 : 1'(8'h77 >> ((i / 8) - 1));
      drive(b, b);
    end
    @(negedge clk);
    rst   = 1'b0;
    RX_IN = 1'b1;
    check_reset_outputs("mid-frame reset");
    @(negedge clk);
    rst       = 1'b1;
    last_good = '0;
    act_q.delete();
    idle(2);
    send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, c0);
    expect_frame(8, 8'h5A, 1'b0, 1'b0, 1'b1, c0);
    idle(3);
    compare_events("after reset");

    // Unsupported Prescale: no response at all.
    Prescale = 6'd6;
    drive(1'b0, 1'b0);
    #1;
    check("prescale6 samp_en", 32'(data_samp_en), 0);
    check("prescale6 edge_cnt", 32'(edge_cnt), 0);
    send_frame(6, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, c0);
    idle(3);
    check("prescale6 P_DATA held", 32'(P_DATA), 32'h5A);
    compare_events("prescale6");

    // Randomized frames against the reference model.
    for (int f = 0; f < 40; f++) begin
      int            p;
      logic [DW-1:0] d;
      bit            pe, pt, flip, stop;
      p    = plist[$urandom_range(0, 3)];
      d    = DW'($urandom);
      pe   = 1'($urandom);
      pt   = 1'($urandom);
      flip = ($urandom_range(0, 4) == 0);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(p, d, pe, pt, flip, stop, c0);
      expect_frame(p, d, pe, flip, stop, c0);
      idle($urandom_range(0, 3));
    end
    idle(3);
    compare_events("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive controller that sits directly around the majority-vote data sampler. It detects the start bit and generates the per-bit edge count and the sampler enable. It consumes the voted `sampled_bit` once per bit, deserializes LSB-first, checks optional parity and the stop bit, and presents a parallel byte with a one-cycle valid strobe to the downstream consumer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (shift register and P_DATA width)

Ports:
clk  input  1  system clock (oversampling clock, Prescale edges per bit)
rst  input  1  asynchronous reset, active-low
RX_IN  input  1  serial line, idle high
Prescale  input  6  oversampling ratio; supported values 4, 8, 16, 32
PAR_EN  input  1  1 = parity bit present after data bits
PAR_TYP  input  1  0 = even parity, 1 = odd parity
sampled_bit  input  1  voted bit from sampler; valid at edge_cnt == Prescale-1
data_samp_en  output  1  enables sampler; sampler clears its samples when low
edge_cnt  output  5  oversampling edge index within current bit, 0..Prescale-1
P_DATA  output  DATA_WIDTH  last good received byte
data_valid  output  1  one-cycle strobe, P_DATA updated this cycle
par_err  output  1  one-cycle strobe, parity mismatch on finished frame
stp_err  output  1  one-cycle strobe, stop bit sampled 0

Behaviour:
- Reset (rst low, async): state IDLE, edge_cnt=0, bit_cnt=0, shift reg=0, P_DATA=0, data_valid=0, par_err=0, stp_err=0. data_samp_en=0.
- States: IDLE, START, DATA, PARITY, STOP. All are registered, and only IDLE holds edge_cnt at 0.
- Supported Prescale is one of 4/8/16/32. Any other value keeps the block in IDLE, ignoring RX_IN.
- data_samp_en (combinational): 1 when state != IDLE, or when state == IDLE with RX_IN == 0 and Prescale supported. Otherwise 0.
- Start detection:
  - In IDLE, the first cycle with RX_IN == 0 counts as edge 0 of the start bit.
  - Next state is START with edge_cnt <= 1.
- Edge counting: in non-IDLE states, edge_cnt increments each cycle. It wraps to 0 after Prescale-1, and the wrap cycle (edge_cnt == Prescale-1) is the bit-end cycle.
- Bit-end actions, each taken on the cycle where edge_cnt == Prescale-1:
  - START: if sampled_bit == 1, the start is false. Go to IDLE with edge_cnt <= 0 and no strobes. Else go to DATA with bit_cnt <= 0.
  - DATA:
    - Shift sampled_bit in LSB-first: shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]}, and bit_cnt++.
    - After bit DATA_WIDTH-1, go to PARITY if PAR_EN == 1, else to STOP.
  - PARITY: compute par_bad = (^shreg ^ PAR_TYP) != sampled_bit, register it internally, then go to STOP.
  - STOP:
    - Go to IDLE with edge_cnt <= 0.
    - On the next cycle, strobe data_valid=1 only if sampled_bit == 1 and no parity error; P_DATA <= shreg in that same cycle.
    - If sampled_bit == 0, strobe stp_err=1 on that next cycle.
    - If par_bad (PAR_EN only), strobe par_err=1 on that next cycle.
    - Both error strobes may assert together. data_valid stays 0 on any error.
- P_DATA holds its value between good frames and is never updated by a bad frame.
- PAR_EN and PAR_TYP are sampled at start detection and held for the whole frame.
- Latency: data_valid is asserted at cycle N×Prescale after the start-detect cycle (cycle 0), with N = DATA_WIDTH+2 (+1 if PAR_EN). Example: Prescale=8, no parity gives cycle 80.
- Back-to-back frames: a low RX_IN on the first cycle in IDLE after STOP starts a new frame. The strobes of the previous frame still issue normally.
- Frame with RX_IN held low (break): stp_err=1, then the block re-detects a start immediately.
- Reset asserted mid-frame: immediate return to reset values. Data is discarded and no strobes issue.
- A Prescale change mid-frame is unsupported; results are undefined until IDLE.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB-first, stop) -> data_valid=1 for one cycle at cycle 80, P_DATA=0xA5, par_err=stp_err=0.
- Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x3C, parity bit 0 -> data_valid at cycle 176, P_DATA=0x3C. Repeat with parity bit 1 -> par_err=1, data_valid=0, P_DATA stays 0x3C.
- Prescale=4, RX_IN low for 2 cycles then high (glitch) -> returns to IDLE at cycle 4 with edge_cnt=0, no strobes, data_samp_en=0 from cycle 4.
- Prescale=32, byte 0xFF with stop bit 0 -> stp_err=1 one cycle, data_valid=0, P_DATA unchanged.
- Prescale=8, two back-to-back frames 0x12 then 0x34 with no idle gap -> data_valid pulses at cycles 80 and 160, with P_DATA=0x12 and 0x34 respectively.
- Prescale=8, rst low at cycle 40 mid-DATA -> all outputs at reset values; a later frame 0x5A is received correctly. Prescale=6 -> no response to frames.
